// File: rtl/iterative_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Recovers operand A from an 8x8 product P and operand B to measure approximate-product error.
module iterative_divider #(
  parameter int N_W = 16,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero,
  output logic           fits8
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N_W-1:0]   dvd_sh;
  logic [N_W-1:0]   quo_w;
  logic [D_W-1:0]   dvs;
  logic [D_W:0]     rem_w;

  logic [D_W+1:0]   step;
  logic             qbit;
  logic [D_W:0]     rem_nx;
  logic [N_W-1:0]   quo_nx;

  // One restoring step: returns {quotient bit, new partial remainder}.
  function automatic logic [D_W+1:0] restore_step(input logic [D_W:0]   r,
                                                  input logic           bit_in,
                                                  input logic [D_W-1:0] d);
    logic [D_W:0] trial;
    trial = {r[D_W-1:0], bit_in};
    if (trial >= {1'b0, d})
      restore_step = {1'b1, trial - {1'b0, d}};
    else
      restore_step = {1'b0, trial};
  endfunction

  always_comb begin
    step   = restore_step(rem_w, dvd_sh[N_W-1], dvs);
    qbit   = step[D_W+1];
    rem_nx = step[D_W:0];
    quo_nx = {quo_w[N_W-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      fits8       <= 1'b0;
      cnt         <= '0;
      dvd_sh      <= '0;
      quo_w       <= '0;
      dvs         <= '0;
      rem_w       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_sh   <= dividend;
            dvs      <= divisor;
            rem_w    <= '0;
            quo_w    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= (divisor == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          rem_w  <= rem_nx;
          quo_w  <= quo_nx;
          dvd_sh <= dvd_sh << 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= quo_nx;
            remainder   <= rem_nx[D_W-1:0];
            div_by_zero <= 1'b0;
            fits8       <= (quo_nx[N_W-1:D_W] == '0);
          end
        end
        DONE: begin
          // Divide-by-zero enters DONE with out_valid low; result is loaded one edge later.
          if (!out_valid) begin
            quotient    <= '1;
            remainder   <= dvd_sh[D_W-1:0];
            div_by_zero <= 1'b1;
            fits8       <= 1'b0;
            out_valid   <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and random bench for iterative_divider; each scenario task checks its own results.
module tb_iterative_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        fits8;

  int checks = 0;
  int errors = 0;

  iterative_divider #(.N_W(16), .D_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .fits8(fits8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for in_ready, presents one operation and returns #1 after the acceptance edge.
  task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL start_ready_timeout in_ready=%0b required=1", in_ready);
    end
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'h0;
    divisor  = 8'h0;
  endtask

  // Counts edges from acceptance until out_valid is seen, up to budget.
  task automatic wait_result(input int budget, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < budget) begin
      @(posedge clk); #1; cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if ({quotient, remainder, div_by_zero, fits8} !== 26'h0) begin
      errors++; $display("FAIL reset_outputs q=%h r=%h dbz=%0b f8=%0b exp all zero", quotient, remainder, div_by_zero, fits8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_directed(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                              input int exp_lat, input logic [15:0] exp_q, input logic [7:0] exp_r,
                              input logic exp_dbz, input logic exp_f8);
    int cyc;
    start_op(dvd, dvs);
    wait_result(40, cyc);
    checks++; if (cyc !== exp_lat || out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_latency got=%0d valid=%0b exp=%0d", name, cyc, out_valid, exp_lat);
    end
    checks++; if (quotient !== exp_q) begin errors++; $display("FAIL %s_quotient got=%h exp=%h", name, quotient, exp_q); end
    checks++; if (remainder !== exp_r) begin errors++; $display("FAIL %s_remainder got=%h exp=%h", name, remainder, exp_r); end
    checks++; if (div_by_zero !== exp_dbz) begin errors++; $display("FAIL %s_dbz got=%0b exp=%0b", name, div_by_zero, exp_dbz); end
    checks++; if (fits8 !== exp_f8) begin errors++; $display("FAIL %s_fits8 got=%0b exp=%0b", name, fits8, exp_f8); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_release out_valid=%0b in_ready=%0b exp 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_exact_product();
    run_directed("prod200x123", 16'h6018, 8'h7B, 16, 16'h00C8, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_general();
    run_directed("d1000by7", 16'h03E8, 8'h07, 16, 16'h008E, 8'h06, 1'b0, 1'b1);
    run_directed("ffffby1", 16'hFFFF, 8'h01, 16, 16'hFFFF, 8'h00, 1'b0, 1'b0);
    run_directed("ffffbyff", 16'hFFFF, 8'hFF, 16, 16'h0101, 8'h00, 1'b0, 1'b0);
    run_directed("small", 16'h0005, 8'h09, 16, 16'h0000, 8'h05, 1'b0, 1'b1);
  endtask

  task automatic test_div_by_zero();
    run_directed("divzero", 16'h1234, 8'h00, 1, 16'hFFFF, 8'h34, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    int cyc;
    start_op(16'h6018, 8'h7B);
    wait_result(40, cyc);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%0b exp=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      dividend = 16'h0101;
      divisor  = 8'h02;
      @(posedge clk); #1;
      checks++; if (quotient !== 16'h00C8 || remainder !== 8'h00) begin
        errors++; $display("FAIL stall_hold_%0d q=%h r=%h exp=00c8/00", i, quotient, remainder);
      end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_ctrl_%0d in_ready=%0b out_valid=%0b exp 0/1", i, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    dividend = 16'h0;
    divisor  = 8'h0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    start_op(16'hFFFF, 8'h03);
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ctrl out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
    checks++; if ({quotient, remainder, div_by_zero, fits8} !== 26'h0) begin
      errors++; $display("FAIL midreset_outputs q=%h r=%h dbz=%0b f8=%0b exp all zero", quotient, remainder, div_by_zero, fits8);
    end
    repeat (20) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_result out_valid=%0b exp=0", out_valid); end
    end
    run_directed("after_reset", 16'h0064, 8'h0A, 16, 16'h000A, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random_products();
    int a, b, n;
    logic got, seen, hs;
    for (int k = 0; k < 1000; k++) begin
      a = $urandom_range(1, 255);
      b = $urandom_range(1, 255);
      start_op(16'(a * b), 8'(b));
      got = 1'b0; seen = 1'b0; n = 0;
      while (!got && n < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && !seen) begin
          seen = 1'b1;
          checks++; if (quotient !== 16'(a) || remainder !== 8'h00 || fits8 !== 1'b1) begin
            errors++; $display("FAIL rand_prod a=%0d b=%0d q=%h r=%h f8=%0b exp q=%h r=00 f8=1",
                               a, b, quotient, remainder, fits8, 16'(a));
          end
        end
        hs = out_valid && out_ready;
        @(posedge clk); #1; n++;
        if (hs) got = 1'b1;
      end
      out_ready = 1'b0;
      if (!got) begin
        checks++; errors++;
        $display("FAIL rand_prod_timeout a=%0d b=%0d out_valid=%0b exp handshake", a, b, out_valid);
      end
    end
  endtask

  task automatic test_random_invariant();
    int dvd, dvs, cyc;
    for (int k = 0; k < 1000; k++) begin
      dvd = $urandom_range(0, 65535);
      dvs = $urandom_range(1, 255);
      start_op(16'(dvd), 8'(dvs));
      wait_result(40, cyc);
      checks++;
      if (out_valid !== 1'b1 || int'(quotient) * dvs + int'(remainder) != dvd || int'(remainder) >= dvs
          || fits8 !== ((dvd / dvs) < 256)) begin
        errors++; $display("FAIL rand_inv dvd=%h dvs=%h q=%h r=%h f8=%0b exp q=%h r=%h",
                           16'(dvd), 8'(dvs), quotient, remainder, fits8, 16'(dvd / dvs), 8'(dvd % dvs));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'h0;
    divisor   = 8'h0;
    @(posedge clk); #1;
    test_reset();
    test_exact_product();
    test_general();
    test_div_by_zero();
    test_stall();
    test_reset_midop();
    test_random_products();
    test_random_invariant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
